// File: rtl/viterbi_decoder_param.sv
// viterbi_decoder_param: streaming hard-decision rate-1/2 Viterbi decoder, parallel ACS, register-exchange survivors
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready   symbol handshake; in_bits = {G0 parity, G1 parity}; in_last ends a block
//   out_valid, out_ready decoded-bit handshake; out_bit, with out_last on the final bit of a block
//   busy                 flushing, or holding accepted symbols whose bits are not yet emitted
module viterbi_decoder_param #(
  parameter int K = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101,
  parameter int TB_DEPTH = 15,
  parameter int PM_W = 8,
  parameter bit TERMINATED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_bits,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);
  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};
  localparam logic [CW-1:0] FULL = CW'(TB_DEPTH);
  localparam logic [CW-1:0] EMIT = CW'(TB_DEPTH - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [PM_W-1:0] pm [NS];
  logic [PM_W-1:0] pm_acs [NS];
  logic [PM_W-1:0] pm_nx [NS];
  logic [TB_DEPTH-1:0] surv [NS];
  logic [TB_DEPTH-1:0] surv_nx [NS];
  logic [NS-1:0] msb;
  logic norm, acc, emit_run, fl_go, done, fl_bit;
  logic [SW-1:0] best, fl_state;
  logic [PM_W-1:0] best_pm;
  logic [CW-1:0] sym_cnt, cnt_inc;

  for (genvar i = 0; i < NS; i++) begin : g_acs
    // predecessors of state i are {i[K-3:0], b}; the input bit that reaches i is i's MSB
    localparam int P0 = (i << 1) % NS;
    localparam logic [K-1:0] R0 = K'(((i >> (K - 2)) << (K - 1)) | P0);
    localparam logic [K-1:0] R1 = R0 | K'(1);
    localparam logic [1:0] E0 = {^(G0 & R0), ^(G1 & R0)};
    localparam logic [1:0] E1 = {^(G0 & R1), ^(G1 & R1)};
    logic [1:0] d0, d1;
    logic [PM_W-1:0] m0, m1;
    logic take1;
    assign d0 = in_bits ^ E0;
    assign d1 = in_bits ^ E1;
    assign m0 = pm[P0] + PM_W'(d0[1]) + PM_W'(d0[0]);
    assign m1 = pm[P0+1] + PM_W'(d1[1]) + PM_W'(d1[0]);
    assign take1 = m1 < m0;
    assign pm_acs[i] = take1 ? m1 : m0;
    assign msb[i] = pm_acs[i][PM_W-1];
    assign pm_nx[i] = {pm_acs[i][PM_W-1] & ~norm, pm_acs[i][PM_W-2:0]};
    assign surv_nx[i] = {take1 ? surv[P0+1][TB_DEPTH-2:0] : surv[P0][TB_DEPTH-2:0], R0[K-1]};
  end

  // lowest metric wins, lowest index on a tie
  always_comb begin
    best = '0;
    best_pm = pm_nx[0];
    for (int s = 1; s < NS; s++)
      if (pm_nx[s] < best_pm) begin
        best = SW'(s);
        best_pm = pm_nx[s];
      end
  end

  // all metrics past half range: drop the MSB everywhere, preserving differences
  assign norm = &msb;
  assign in_ready = state == RUN && !(out_valid && !out_ready);
  assign acc = in_valid && in_ready;
  assign emit_run = acc && sym_cnt >= EMIT;
  assign fl_go = state == FLUSH && (!out_valid || out_ready) && sym_cnt != '0;
  assign done = state == FLUSH && out_valid && out_ready && out_last;
  assign cnt_inc = sym_cnt == FULL ? sym_cnt : sym_cnt + ONE;
  // in FLUSH sym_cnt counts remaining bits, so the oldest pending one sits at sym_cnt-1
  assign fl_bit = 1'(surv[fl_state] >> (sym_cnt - ONE));
  assign busy = state == FLUSH || sym_cnt != '0 || out_valid;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (acc && in_last) state_nx = FLUSH;
    else if (done) state_nx = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt <= '0;
      fl_state <= '0;
      for (int s = 0; s < NS; s++) begin
        pm[s] <= (s == 0) ? '0 : PM_INIT;
        surv[s] <= '0;
      end
    end else if (done) begin
      sym_cnt <= '0;
      for (int s = 0; s < NS; s++) begin
        pm[s] <= (s == 0) ? '0 : PM_INIT;
        surv[s] <= '0;
      end
    end else if (acc) begin
      pm <= pm_nx;
      surv <= surv_nx;
      sym_cnt <= in_last ? (cnt_inc == FULL ? EMIT : cnt_inc) : cnt_inc;
      if (in_last) fl_state <= TERMINATED ? '0 : best;
    end else if (fl_go) begin
      sym_cnt <= sym_cnt - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
    end else if (emit_run) begin
      out_valid <= 1'b1;
      out_bit <= surv_nx[best][TB_DEPTH-1];
      out_last <= 1'b0;
    end else if (fl_go) begin
      out_valid <= 1'b1;
      out_bit <= fl_bit;
      out_last <= sym_cnt == ONE;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end
  end
endmodule
